// File: rtl/bus_control_ws_if.sv
// 68000 bus pins seen by the bus controller: CPU strobes/address in, acknowledges and chip selects out.
interface bus_control_ws_if #(
  parameter int unsigned RAM_BANKS = 1
);
  logic                 AS_IN;
  logic                 RW_IN;
  logic                 UDS_IN;
  logic                 LDS_IN;
  logic [23:0]          ADDR_IN;
  logic                 DTACK;
  logic                 BERR;
  logic                 PROMCS0;
  logic                 PROMCS1;
  logic [RAM_BANKS-1:0] SRAMCS0;
  logic [RAM_BANKS-1:0] SRAMCS1;
  logic                 OE;

  modport master (
    output AS_IN, RW_IN, UDS_IN, LDS_IN, ADDR_IN,
    input  DTACK, BERR, PROMCS0, PROMCS1, SRAMCS0, SRAMCS1, OE
  );

  modport slave (
    input  AS_IN, RW_IN, UDS_IN, LDS_IN, ADDR_IN,
    output DTACK, BERR, PROMCS0, PROMCS1, SRAMCS0, SRAMCS1, OE
  );
endinterface

// File: rtl/bus_control_ws.sv
// 68000 bus controller: reset sequencing, ROM/SRAM decode, wait states, DTACK and bus-error timeout.
// Optional single-step stepper is built when the STEPPER_EN macro is defined.
module bus_control_ws #(
  parameter int unsigned RESET_CYCLES = 10000,
  parameter int unsigned RAM_BANKS    = 1,
  parameter int unsigned ROM_WAIT     = 1,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned BERR_TIMEOUT = 64
) (
  input  logic           CPUCLK_IN,
  input  logic           RESET_IN,
  input  logic           STEPEN_IN,
  input  logic           STEP_IN,
  bus_control_ws_if.slave bus,
  output logic           RESET,
  output logic           HALT,
  output logic           RUN
);

  localparam int unsigned CNT_W  = 14;
  localparam int unsigned WAIT_W = 8;

`ifdef STEPPER_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACK, S_BERR, S_STEP, S_RELEASE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACK, S_BERR
  } state_e;
  logic unused_step;
  assign unused_step = STEPEN_IN ^ STEP_IN;
`endif

  logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              run_q, run_d;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              tmo_q, tmo_d;
  logic              dtack_q, dtack_d;
  logic              berr_q, berr_d;

  logic [3:0]           region;
  logic                 rom_hit;
  logic [RAM_BANKS-1:0] ram_hit;
  logic                 ram_any;
  logic                 asreq;
  logic                 dtreq;
  logic [19:0]          unused_addr;

  assign unused_addr = bus.ADDR_IN[19:0];

  // Power-on sequencing: count cycles after release, then hold RUN
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    run_d     = run_q;
    if (!run_q) begin
      if (rst_cnt_q == CNT_W'(RESET_CYCLES)) begin
        run_d = 1'b1;
      end else begin
        rst_cnt_d = rst_cnt_q + CNT_W'(1);
      end
    end
  end

  // Address decode on the top nibble
  always_comb begin
    region  = bus.ADDR_IN[23:20];
    rom_hit = (region == 4'h0) || (region == 4'hF);
    ram_hit = '0;
    for (int unsigned i = 0; i < RAM_BANKS; i++) begin
      ram_hit[i] = (region == 4'(i + 1));
    end
    ram_any = |ram_hit;
    asreq   = run_q & bus.AS_IN;
    dtreq   = asreq & (bus.UDS_IN | bus.LDS_IN);
  end

  assign bus.PROMCS0 = asreq & rom_hit & bus.RW_IN & bus.UDS_IN;
  assign bus.PROMCS1 = asreq & rom_hit & bus.RW_IN & bus.LDS_IN;
  assign bus.SRAMCS0 = ram_hit & {RAM_BANKS{asreq & bus.UDS_IN}};
  assign bus.SRAMCS1 = ram_hit & {RAM_BANKS{asreq & bus.LDS_IN}};
  assign bus.OE      = asreq & (rom_hit | ram_any) & bus.RW_IN;

  // Where a mapped access goes once its wait states are spent
  state_e done_state;
  logic   done_dtack;
  always_comb begin
`ifdef STEPPER_EN
    done_state = STEPEN_IN ? S_STEP : S_ACK;
    done_dtack = ~STEPEN_IN;
`else
    done_state = S_ACK;
    done_dtack = 1'b1;
`endif
  end

  logic [WAIT_W-1:0] wait_ld;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    dtack_d = 1'b0;
    berr_d  = 1'b0;
    wait_ld = '0;
    if (!run_q) begin
      state_d = S_IDLE;
      tmo_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dtreq) begin
            tmo_d = 1'b0;
            if (rom_hit && !bus.RW_IN) begin
              state_d = S_BERR;
              berr_d  = 1'b1;
            end else if (rom_hit || ram_any) begin
              wait_ld = rom_hit ? WAIT_W'(ROM_WAIT) : WAIT_W'(RAM_WAIT);
              if (wait_ld == '0) begin
                state_d = done_state;
                dtack_d = done_dtack;
              end else begin
                state_d = S_WAIT;
                wcnt_d  = wait_ld;
              end
            end else begin
              state_d = S_WAIT;
              wcnt_d  = WAIT_W'(BERR_TIMEOUT);
              tmo_d   = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!dtreq) begin
            state_d = S_IDLE;
          end else if (wcnt_q == WAIT_W'(1)) begin
            if (tmo_q) begin
              state_d = S_BERR;
              berr_d  = 1'b1;
            end else begin
              state_d = done_state;
              dtack_d = done_dtack;
            end
          end else begin
            wcnt_d = wcnt_q - WAIT_W'(1);
          end
        end
        S_ACK: begin
          if (!dtreq) begin
`ifdef STEPPER_EN
            state_d = STEPEN_IN ? S_RELEASE : S_IDLE;
`else
            state_d = S_IDLE;
`endif
          end else begin
            dtack_d = 1'b1;
          end
        end
        S_BERR: begin
          if (!bus.AS_IN) begin
            state_d = S_IDLE;
          end else begin
            berr_d = 1'b1;
          end
        end
`ifdef STEPPER_EN
        S_STEP: begin
          if (!dtreq) begin
            state_d = S_IDLE;
          end else if (STEP_IN || !STEPEN_IN) begin
            state_d = S_ACK;
            dtack_d = 1'b1;
          end
        end
        // One bus cycle per press: wait for the button to come back up
        S_RELEASE: begin
          if (!STEP_IN) begin
            state_d = S_IDLE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      rst_cnt_q <= '0;
      run_q     <= 1'b0;
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      tmo_q     <= 1'b0;
      dtack_q   <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      run_q     <= run_d;
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
    end
  end

  assign RUN       = run_q;
  assign RESET     = ~run_q;
  assign HALT      = ~run_q;
  assign bus.DTACK = dtack_q;
  assign bus.BERR  = berr_q;

endmodule
